// File: rtl/ctrl_pkt_pkg.sv
// Shared definitions for the control-packet transmit path: default packet size,
// read-side FSM states and the byte-pointer width helper.
package ctrl_pkt_pkg;

    localparam int PKT_BYTES_DEF = 64;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } tx_state_t;

    // Byte pointer width for a packet of the given (power-of-two) size.
    function automatic int ptr_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/ctrl_pkt_tx_if.sv
// CPU write port and USB-endpoint streaming port of the control-packet transmitter.
interface ctrl_pkt_tx_if;

    logic       wr;
    logic [7:0] d;
    logic       wrfull;
    logic       ovf;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output wr, d, out_ready,
        input  wrfull, ovf, out_data, out_valid, out_last
    );

    modport slave (
        input  wr, d, out_ready,
        output wrfull, ovf, out_data, out_valid, out_last
    );

endinterface

// File: rtl/ctrl_pkt_ram.sv
// Two-bank byte storage for the ping-pong packet buffers: one synchronous write
// port, one asynchronous read port. Contents are deliberately left unreset.
module ctrl_pkt_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wbank,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          rbank,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [0:2*DEPTH-1];

    // Byte write into the selected bank
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[{wbank, waddr}] <= wdata;
        end
    end

    assign rdata = mem_r[{rbank, raddr}];

endmodule

// File: rtl/ctrl_pkt_tx.sv
// Control-packet transmitter: CPU bytes fill ping-pong buffers; complete packets
// are streamed in order to the USB endpoint FIFO with valid/ready/last framing.
module ctrl_pkt_tx
    import ctrl_pkt_pkg::*;
#(
    parameter int PKT_BYTES = PKT_BYTES_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    ctrl_pkt_tx_if.slave  bus
);

    localparam int            PW       = ptr_width(PKT_BYTES);
    localparam logic [PW-1:0] PTR_LAST = PW'(PKT_BYTES - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic          wbuf_r;
    logic          rbuf_r;
    logic [1:0]    pkt_cnt_r;
    logic [1:0]    pkt_cnt_s;
    logic          wrfull_r;
    logic          ovf_r;
    tx_state_t     state_r;
    tx_state_t     state_s;

    logic          wr_ok_s;
    logic          ram_we_s;
    logic          complete_s;
    logic          stream_s;
    logic          last_s;
    logic          xfer_s;
    logic          done_s;
    logic [7:0]    ram_rdata_s;

    ctrl_pkt_ram #(
        .DEPTH (PKT_BYTES),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .wbank (wbuf_r),
        .waddr (wptr_r),
        .wdata (bus.d),
        .rbank (rbuf_r),
        .raddr (rptr_r),
        .rdata (ram_rdata_s)
    );

    // Handshake qualifiers for both sides of the buffer
    always_comb begin
        wr_ok_s    = bus.wr & ~wrfull_r;
        ram_we_s   = wr_ok_s & ~flush;
        complete_s = wr_ok_s & (wptr_r == PTR_LAST);
        stream_s   = (state_r == ST_STREAM);
        last_s     = stream_s & (rptr_r == PTR_LAST);
        xfer_s     = stream_s & bus.out_ready;
        done_s     = xfer_s & last_s;
    end

    // Completed-packet count; a completion and a final-byte transfer cancel out
    always_comb begin
        pkt_cnt_s = pkt_cnt_r;
        case ({complete_s, done_s})
            2'b10:   pkt_cnt_s = pkt_cnt_r + 2'd1;
            2'b01:   pkt_cnt_s = pkt_cnt_r - 2'd1;
            default: pkt_cnt_s = pkt_cnt_r;
        endcase
    end

    // Read-side next state; looks at the updated count so streaming starts the cycle after completion
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pkt_cnt_s != 2'd0) begin
                    state_s = ST_STREAM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (done_s && (pkt_cnt_s == 2'd0)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Read-side state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else if (flush) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Pointers, bank selects, packet count and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_r    <= {PW{1'b0}};
            rptr_r    <= {PW{1'b0}};
            wbuf_r    <= 1'b0;
            rbuf_r    <= 1'b0;
            pkt_cnt_r <= 2'd0;
            wrfull_r  <= 1'b0;
            ovf_r     <= 1'b0;
        end else if (flush) begin
            wptr_r    <= {PW{1'b0}};
            rptr_r    <= {PW{1'b0}};
            wbuf_r    <= 1'b0;
            rbuf_r    <= 1'b0;
            pkt_cnt_r <= 2'd0;
            wrfull_r  <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wptr_r <= wptr_r + PTR_ONE;
                if (complete_s) begin
                    wbuf_r <= ~wbuf_r;
                end
            end
            if (xfer_s) begin
                if (last_s) begin
                    rptr_r <= {PW{1'b0}};
                    rbuf_r <= ~rbuf_r;
                end else begin
                    rptr_r <= rptr_r + PTR_ONE;
                end
            end
            pkt_cnt_r <= pkt_cnt_s;
            wrfull_r  <= (pkt_cnt_s == 2'd2);
            if (bus.wr && wrfull_r) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign bus.wrfull    = wrfull_r;
    assign bus.ovf       = ovf_r;
    assign bus.out_valid = stream_s;
    assign bus.out_last  = last_s;
    // Storage is unreset, so the data path is forced to zero outside STREAM
    assign bus.out_data  = stream_s ? ram_rdata_s : 8'h00;

endmodule

// File: tb/tb_ctrl_pkt_tx.sv
// Directed self-checking bench for ctrl_pkt_tx: single packet, backpressure/overflow,
// flush, streaming, random stalls and asynchronous reset mid-stream.
module tb_ctrl_pkt_tx;

    localparam int PB = 64;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic flush   = 1'b0;

    ctrl_pkt_tx_if bus ();

    ctrl_pkt_tx #(
        .PKT_BYTES (PB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int         checks     = 0;
    int         errors     = 0;
    logic [7:0] exp_q [$];
    logic       lst_q [$];
    int         exp_pos    = 0;
    int         cyc        = 0;
    int         xfer_cnt   = 0;
    int         first_cyc  = -1;
    int         last_cyc   = 0;
    int         stall_cnt  = 0;
    int         vcnt       = 0;
    bit         stall_en   = 1'b0;
    bit         saw_full   = 1'b0;
    bit         hold_v     = 1'b0;
    logic [7:0] hold_d     = 8'h00;
    logic       hold_l     = 1'b0;
    bit         rnd_run    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic write_bytes(input logic [7:0] base, input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = base + 8'(i);
            bus.wr = 1'b1;
            bus.d  = b;
            if (push) begin
                exp_q.push_back(b);
                lst_q.push_back(exp_pos == PB - 1);
                exp_pos = (exp_pos + 1) % PB;
            end
            step();
        end
        bus.wr = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !bus.out_valid) break;
            step();
        end
        check_eq({tag, "_pending"}, exp_q.size(), 32'd0);
        check_eq({tag, "_idle"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic count_valid(input int n);
        vcnt = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.out_valid) vcnt++;
            step();
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard against written bytes and stall-stability check
    always @(negedge clk) begin
        if (bus.wrfull) saw_full = 1'b1;
        if (stall_en && hold_v) begin
            check_eq("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            check_eq("stall_data", {24'd0, bus.out_data}, {24'd0, hold_d});
            check_eq("stall_last", {31'd0, bus.out_last}, {31'd0, hold_l});
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                logic [7:0] ed;
                logic       el;
                ed = exp_q.pop_front();
                el = lst_q.pop_front();
                check_eq("out_data", {24'd0, bus.out_data}, {24'd0, ed});
                check_eq("out_last", {31'd0, bus.out_last}, {31'd0, el});
            end
            xfer_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        hold_v = bus.out_valid && !bus.out_ready;
        if (hold_v) stall_cnt++;
        hold_d = bus.out_data;
        hold_l = bus.out_last;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wr        = 1'b0;
        bus.d         = 8'h00;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (3) step();
        check_eq("rst_wrfull", {31'd0, bus.wrfull}, 32'd0);
        check_eq("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_last", {31'd0, bus.out_last}, 32'd0);
        check_eq("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        check_eq("rst_data", {24'd0, bus.out_data}, 32'd0);
        reset_n = 1'b1;
        step();

        // Single packet 0x00..0x3F
        bus.out_ready = 1'b1;
        write_bytes(8'h00, PB - 1, 1'b1);
        check_eq("pre_valid", {31'd0, bus.out_valid}, 32'd0);
        write_bytes(8'h3F, 1, 1'b1);
        check_eq("first_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("first_data", {24'd0, bus.out_data}, 32'h00);
        check_eq("first_last", {31'd0, bus.out_last}, 32'd0);
        wait_drain("single");

        // Backpressure: two packets fill the buffers, the third is dropped
        bus.out_ready = 1'b0;
        write_bytes(8'h40, PB, 1'b1);
        check_eq("bp_wrfull_1", {31'd0, bus.wrfull}, 32'd0);
        write_bytes(8'h80, PB - 1, 1'b1);
        check_eq("bp_wrfull_early", {31'd0, bus.wrfull}, 32'd0);
        write_bytes(8'hBF, 1, 1'b1);
        check_eq("bp_wrfull_2", {31'd0, bus.wrfull}, 32'd1);
        check_eq("bp_ovf_before", {31'd0, bus.ovf}, 32'd0);
        write_bytes(8'hC0, 1, 1'b0);
        check_eq("bp_ovf_set", {31'd0, bus.ovf}, 32'd1);
        write_bytes(8'hC1, PB - 1, 1'b0);
        check_eq("bp_wrfull_hold", {31'd0, bus.wrfull}, 32'd1);
        bus.out_ready = 1'b1;
        wait_drain("bp");
        check_eq("bp_wrfull_clear", {31'd0, bus.wrfull}, 32'd0);
        check_eq("bp_ovf_sticky", {31'd0, bus.ovf}, 32'd1);

        // Flush after a partial packet, together with a write
        write_bytes(8'h10, 20, 1'b0);
        bus.wr = 1'b1;
        bus.d  = 8'hEE;
        flush  = 1'b1;
        step();
        bus.wr = 1'b0;
        flush  = 1'b0;
        check_eq("fl_ovf", {31'd0, bus.ovf}, 32'd0);
        check_eq("fl_wrfull", {31'd0, bus.wrfull}, 32'd0);
        count_valid(80);
        check_eq("fl_no_output", vcnt, 32'd0);
        write_bytes(8'h20, PB, 1'b1);
        wait_drain("fl");

        // Streaming: four back-to-back packets, no gaps
        xfer_cnt  = 0;
        first_cyc = -1;
        saw_full  = 1'b0;
        write_bytes(8'h01, PB, 1'b1);
        write_bytes(8'h41, PB, 1'b1);
        check_eq("sim_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("sim_data", {24'd0, bus.out_data}, 32'h41);
        check_eq("sim_wrfull", {31'd0, bus.wrfull}, 32'd0);
        write_bytes(8'h81, PB, 1'b1);
        write_bytes(8'hC1, PB, 1'b1);
        wait_drain("stream");
        check_eq("stream_count", xfer_cnt, 32'd256);
        check_eq("stream_span", last_cyc - first_cyc, 32'd255);
        check_eq("stream_no_full", {31'd0, saw_full}, 32'd0);
        check_eq("stream_ovf", {31'd0, bus.ovf}, 32'd0);

        // Random stalls at 50%
        stall_cnt = 0;
        stall_en  = 1'b1;
        rnd_run   = 1'b1;
        fork
            begin
                while (rnd_run) begin
                    @(posedge clk);
                    #2;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        write_bytes(8'h33, PB, 1'b1);
        write_bytes(8'h99, PB, 1'b1);
        wait_drain("stall");
        rnd_run = 1'b0;
        step();
        step();
        bus.out_ready = 1'b1;
        stall_en      = 1'b0;
        check_eq("stall_seen", {31'd0, (stall_cnt > 0)}, 32'd1);
        check_eq("stall_ovf", {31'd0, bus.ovf}, 32'd0);

        // Asynchronous reset mid-stream and mid-packet
        write_bytes(8'h10, PB, 1'b1);
        write_bytes(8'h70, 30, 1'b0);
        check_eq("mid_valid", {31'd0, bus.out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("arst_last", {31'd0, bus.out_last}, 32'd0);
        check_eq("arst_data", {24'd0, bus.out_data}, 32'd0);
        check_eq("arst_wrfull", {31'd0, bus.wrfull}, 32'd0);
        exp_q.delete();
        lst_q.delete();
        exp_pos = 0;
        repeat (3) step();
        reset_n = 1'b1;
        count_valid(80);
        check_eq("arst_no_output", vcnt, 32'd0);
        write_bytes(8'hA0, PB, 1'b1);
        wait_drain("arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
